// File: rtl/bsg_sort4_pipe_pkg.sv
// Shared constants and types for the bsg_sort4_pipe sorting network.
package bsg_sort4_pipe_pkg;

  localparam int unsigned els_gp              = 4;
  localparam int unsigned stages_gp           = 3;
  localparam int unsigned pairs_per_layer_gp  = 2;
  localparam int unsigned swap_tally_width_gp = 3;
  localparam int unsigned swap_count_width_gp = 16;

  typedef logic [swap_tally_width_gp-1:0] tally_t;
  typedef logic [swap_count_width_gp-1:0] count_t;

  // One compare-and-swap cell: orders el[a] <= el[b]; en=0 marks an unused slot.
  typedef struct packed {
    logic       en;
    logic [1:0] a;
    logic [1:0] b;
  } cas_pair_t;

  typedef cas_pair_t [pairs_per_layer_gp-1:0] layer_pairs_t;

  localparam layer_pairs_t cas_table_gp [stages_gp] = '{
    '{0: cas_pair_t'{en: 1'b1, a: 2'd0, b: 2'd1}, 1: cas_pair_t'{en: 1'b1, a: 2'd2, b: 2'd3}},
    '{0: cas_pair_t'{en: 1'b1, a: 2'd0, b: 2'd2}, 1: cas_pair_t'{en: 1'b1, a: 2'd1, b: 2'd3}},
    '{0: cas_pair_t'{en: 1'b1, a: 2'd1, b: 2'd2}, 1: cas_pair_t'{en: 1'b0, a: 2'd0, b: 2'd0}}
  };

endpackage

// File: rtl/bsg_sort4_pipe_stage.sv
// One compare-and-swap layer followed by its valid/data register.
// Optional swap tally under BSG_SORT4_PIPE_STATS_EN.
module bsg_sort4_pipe_stage
  import bsg_sort4_pipe_pkg::*;
#(
  parameter int unsigned  width_p = 16,
  parameter layer_pairs_t pairs_p = '0
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [els_gp*width_p-1:0]  data_i,
`ifdef BSG_SORT4_PIPE_STATS_EN
  input  tally_t                     tally_i,
  output tally_t                     tally_o,
`endif
  input  logic                       ready_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [els_gp*width_p-1:0]  data_o
);

  logic                      v_q, v_d;
  logic [els_gp*width_p-1:0] data_q, data_d;
  logic [els_gp*width_p-1:0] cas_data;
  logic [width_p-1:0]        el [els_gp];
  logic [width_p-1:0]        tmp;
  logic                      load;
`ifdef BSG_SORT4_PIPE_STATS_EN
  tally_t                    swaps;
  tally_t                    tally_q, tally_d;
`endif

  // Apply this layer's CAS cells; strict compare so ties never swap.
  always_comb begin
    tmp = '0;
    for (int unsigned k = 0; k < els_gp; k++) el[k] = data_i[k*width_p +: width_p];
`ifdef BSG_SORT4_PIPE_STATS_EN
    swaps = '0;
`endif
    for (int unsigned p = 0; p < pairs_per_layer_gp; p++) begin
      if (pairs_p[p].en && (el[pairs_p[p].a] > el[pairs_p[p].b])) begin
        tmp               = el[pairs_p[p].a];
        el[pairs_p[p].a]  = el[pairs_p[p].b];
        el[pairs_p[p].b]  = tmp;
`ifdef BSG_SORT4_PIPE_STATS_EN
        swaps             = swaps + tally_t'(1);
`endif
      end
    end
    cas_data = '0;
    for (int unsigned k = 0; k < els_gp; k++) cas_data[k*width_p +: width_p] = el[k];
  end

  // Stage can take new data when empty or when its contents leave this cycle.
  assign ready_o = ~v_q | ready_i;
  assign load    = v_i & ready_o;
  assign v_o     = v_q;
  assign data_o  = data_q;

  // Next-state: load on upstream transfer, clear valid when drained into a bubble.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
`ifdef BSG_SORT4_PIPE_STATS_EN
    tally_d = tally_q;
`endif
    if (load) begin
      v_d    = 1'b1;
      data_d = cas_data;
`ifdef BSG_SORT4_PIPE_STATS_EN
      tally_d = tally_i + swaps;
`endif
    end else if (ready_i) begin
      v_d = 1'b0;
    end
  end

  // Stage register with asynchronous clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
`ifdef BSG_SORT4_PIPE_STATS_EN
      tally_q <= '0;
`endif
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
`ifdef BSG_SORT4_PIPE_STATS_EN
      tally_q <= tally_d;
`endif
    end
  end

`ifdef BSG_SORT4_PIPE_STATS_EN
  assign tally_o = tally_q;
`endif

endmodule

// File: rtl/bsg_sort4_pipe.sv
// Three-stage pipelined 4-element ascending sorter with valid/ready in, valid/yumi out.
// Optional swap statistics counter under BSG_SORT4_PIPE_STATS_EN.
module bsg_sort4_pipe
  import bsg_sort4_pipe_pkg::*;
#(
  parameter int unsigned width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [els_gp*width_p-1:0]  data_i,
  output logic                       ready_o,
`ifdef BSG_SORT4_PIPE_STATS_EN
  output logic [15:0]                swap_count_o,
`endif
  output logic                       v_o,
  output logic [els_gp*width_p-1:0]  data_o,
  input  logic                       yumi_i
);

  // Index 0 is the input side, index stages_gp is the output side.
  logic [stages_gp:0]                           v_s;
  logic [stages_gp:0]                           ready_s;
  logic [stages_gp:0][els_gp*width_p-1:0]       data_s;
`ifdef BSG_SORT4_PIPE_STATS_EN
  logic [stages_gp:0][swap_tally_width_gp-1:0]  tally_s;
  count_t                                       count_q, count_d;
  logic [swap_count_width_gp:0]                 count_sum;
`endif

  assign v_s[0]            = v_i;
  assign data_s[0]         = data_i;
  assign ready_s[stages_gp] = yumi_i;
  assign ready_o           = ready_s[0];
  assign v_o               = v_s[stages_gp];
  assign data_o            = data_s[stages_gp];
`ifdef BSG_SORT4_PIPE_STATS_EN
  assign tally_s[0]        = '0;
`endif

  for (genvar s = 0; s < stages_gp; s++) begin : g_stage
    bsg_sort4_pipe_stage #(
      .width_p (width_p),
      .pairs_p (cas_table_gp[s])
    ) u_stage (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (v_s[s]),
      .data_i    (data_s[s]),
`ifdef BSG_SORT4_PIPE_STATS_EN
      .tally_i   (tally_s[s]),
      .tally_o   (tally_s[s+1]),
`endif
      .ready_i   (ready_s[s+1]),
      .ready_o   (ready_s[s]),
      .v_o       (v_s[s+1]),
      .data_o    (data_s[s+1])
    );
  end

`ifdef BSG_SORT4_PIPE_STATS_EN
  // Saturating accumulation of swaps carried by each consumed vector.
  always_comb begin
    count_sum = {1'b0, count_q} + (swap_count_width_gp+1)'(tally_s[stages_gp]);
    count_d   = count_q;
    if (v_o & yumi_i) count_d = count_sum[swap_count_width_gp] ? '1 : count_sum[swap_count_width_gp-1:0];
  end

  // Swap counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) count_q <= '0;
    else            count_q <= count_d;
  end

  assign swap_count_o = count_q;
`endif

endmodule
